// File: rtl/tlcd_text_formatter.sv
// Text-LCD formatter: latches title/value, converts the value with a sequential double-dabble,
// builds both line strings and strobes ENABLE. Optional hex rendering under `TLCD_HEX_EN.
module tlcd_text_formatter #(
  parameter int unsigned ENABLE_HIGH  = 2,
  parameter int unsigned REFRESH_HOLD = 65000
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         UPDATE,
  input  logic [127:0] TITLE,
  input  logic [15:0]  VALUE,
`ifdef TLCD_HEX_EN
  input  logic         HEX_MODE,
`endif
  output logic [127:0] TEXT_STRING_UPPER,
  output logic [127:0] TEXT_STRING_LOWER,
  output logic         ENABLE,
  output logic         BUSY
);

  localparam int unsigned CNT_W     = 17;
  localparam int unsigned VAL_W     = 16;
  localparam int unsigned BCD_W     = 20;
  localparam int unsigned STR_W     = 128;
  localparam int unsigned CONV_LAST = 15;
  localparam logic [STR_W-1:0] BLANK_LINE = {16{8'h20}};
  localparam logic [63:0]      PREFIX     = 64'h56414C5545203D20;

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_FMT, S_PULSE, S_HOLD} state_t;

  state_t             state_q;
  logic               pending_q;
  logic [STR_W-1:0]   title_q;
  logic [VAL_W-1:0]   value_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_d;
  logic [15:0]        bcd_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic [STR_W-1:0]   upper_q;
  logic [STR_W-1:0]   lower_q;
  logic [STR_W-1:0]   lower_d;
  logic [39:0]        dig_ch;
  logic               lead;
  logic               enable_q;
  logic               busy_q;
`ifdef TLCD_HEX_EN
  logic               hex_q;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
`endif

  assign TEXT_STRING_UPPER = upper_q;
  assign TEXT_STRING_LOWER = lower_q;
  assign ENABLE            = enable_q;
  assign BUSY              = busy_q;

  // Double-dabble step. The ten-thousands nibble never reaches 5 before the last shift
  // (a 16-bit value tops out at 6xxxx), so only the lower four nibbles need the +3 correction.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_d = {bcd_q[18:16], bcd_adj, value_q[4'hF - cnt_q[3:0]]};
  end

  // Lower-line image: leading zeros blanked, units digit always shown.
  always_comb begin
    lead   = 1'b1;
    dig_ch = '0;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
        dig_ch[8*i +: 8] = 8'h20;
      end else begin
        lead             = 1'b0;
        dig_ch[8*i +: 8] = 8'h30 + {4'h0, bcd_q[4*i +: 4]};
      end
    end
    dig_ch[7:0] = 8'h30 + {4'h0, bcd_q[3:0]};
    lower_d     = {PREFIX, dig_ch, 24'h202020};
`ifdef TLCD_HEX_EN
    if (hex_q) begin
      lower_d = {PREFIX, 16'h3078, hex_char(value_q[15:12]), hex_char(value_q[11:8]),
                 hex_char(value_q[7:4]), hex_char(value_q[3:0]), 16'h2020};
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      title_q   <= '0;
      value_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      upper_q   <= BLANK_LINE;
      lower_q   <= BLANK_LINE;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef TLCD_HEX_EN
      hex_q     <= 1'b0;
`endif
    end else begin
      // Requests arriving while busy coalesce into one deferred refresh.
      if ((state_q != S_IDLE) && UPDATE) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (UPDATE || pending_q) begin
            title_q   <= TITLE;
            value_q   <= VALUE;
`ifdef TLCD_HEX_EN
            hex_q     <= HEX_MODE;
`endif
            pending_q <= 1'b0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          if (cnt_q == CNT_W'(CONV_LAST)) begin
            cnt_q   <= '0;
            state_q <= S_FMT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FMT: begin
          upper_q <= title_q;
          lower_q <= lower_d;
          state_q <= S_PULSE;
        end
        S_PULSE: begin
          if (cnt_q == CNT_W'(ENABLE_HIGH)) begin
            enable_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_HOLD;
          end else begin
            enable_q <= 1'b1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_W'(REFRESH_HOLD - 1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlcd_text_formatter.sv
// Bench for tlcd_text_formatter: directed scenarios plus random traffic, all checked each cycle
// against a timeline-based reference model.
module tb_tlcd_text_formatter;

  localparam int unsigned EH   = 2;
  localparam int unsigned RH   = 40;
  localparam int          LAST = 18 + EH + RH;
  localparam logic [127:0] BL  = {16{8'h20}};

  logic         CLK = 1'b0;
  logic         RESETN;
  logic         UPDATE;
  logic [127:0] TITLE;
  logic [15:0]  VALUE;
`ifdef TLCD_HEX_EN
  logic         HEX_MODE;
`endif
  logic [127:0] TEXT_STRING_UPPER;
  logic [127:0] TEXT_STRING_LOWER;
  logic         ENABLE;
  logic         BUSY;

  always #5 CLK = ~CLK;

  tlcd_text_formatter #(.ENABLE_HIGH(EH), .REFRESH_HOLD(RH)) dut (
    .CLK               (CLK),
    .RESETN            (RESETN),
    .UPDATE            (UPDATE),
    .TITLE             (TITLE),
    .VALUE             (VALUE),
`ifdef TLCD_HEX_EN
    .HEX_MODE          (HEX_MODE),
`endif
    .TEXT_STRING_UPPER (TEXT_STRING_UPPER),
    .TEXT_STRING_LOWER (TEXT_STRING_LOWER),
    .ENABLE            (ENABLE),
    .BUSY              (BUSY)
  );

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic en_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] s2b(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  // Expected lower line from the textual rules: right-aligned decimal with blanked leading zeros,
  // or "0x" plus four uppercase hex digits.
  function automatic logic [127:0] exp_line(input logic [15:0] v, input bit hex);
    logic [7:0]   b [16];
    logic [63:0]  pre;
    logic [127:0] r;
    int           p10 [5];
    int           vi;
    int           n;
    p10 = '{10000, 1000, 100, 10, 1};
    pre = "VALUE = ";
    vi  = int'(v);
    for (int i = 0; i < 8; i++) b[i] = pre[63-8*i -: 8];
    for (int i = 8; i < 16; i++) b[i] = 8'h20;
    if (hex) begin
      b[8] = 8'h30;
      b[9] = 8'h78;
      for (int k = 0; k < 4; k++) begin
        n = (vi >> (12 - 4*k)) & 15;
        b[10+k] = (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
      end
    end else begin
      for (int k = 0; k < 5; k++) begin
        b[8+k] = (k < 4 && vi < p10[k]) ? 8'h20 : 8'(8'h30 + (vi / p10[k]) % 10);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  // Reference model: each accepted request at edge t0 defines a fixed timeline.
  int           m_e      = 0;
  int           m_t0     = 0;
  bit           m_active = 1'b0;
  bit           m_pend   = 1'b0;
  logic [15:0]  m_val    = '0;
  logic [127:0] m_title  = '0;
  bit           m_hex    = 1'b0;
  logic [127:0] m_upper  = BL;
  logic [127:0] m_lower  = BL;
  logic         m_en     = 1'b0;
  logic         m_busy   = 1'b0;

  always @(posedge CLK) begin : model
    int e;
    int t;
    bit bb;
    bit acc;
    bit hin;
    e = m_e + 1;
    m_e <= e;
`ifdef TLCD_HEX_EN
    hin = HEX_MODE;
`else
    hin = 1'b0;
`endif
    if (!RESETN) begin
      m_active <= 1'b0;
      m_pend   <= 1'b0;
      m_upper  <= BL;
      m_lower  <= BL;
      m_en     <= 1'b0;
      m_busy   <= 1'b0;
    end else begin
      bb  = m_active && (e > m_t0) && (e <= m_t0 + LAST);
      acc = !bb && (UPDATE || m_pend);
      t   = acc ? e : m_t0;
      if (acc) begin
        m_t0     <= e;
        m_active <= 1'b1;
        m_val    <= VALUE;
        m_title  <= TITLE;
        m_hex    <= hin;
        m_pend   <= 1'b0;
      end else if (bb && UPDATE) begin
        m_pend <= 1'b1;
      end
      if (m_active && !acc && e == t + 17) begin
        m_upper <= m_title;
        m_lower <= exp_line(m_val, m_hex);
      end
      m_busy <= (acc || m_active) && (e >= t) && (e < t + LAST);
      m_en   <= (acc || m_active) && (e >= t + 18) && (e < t + 18 + EH);
    end
  end

  always @(negedge CLK) begin : compare
    if (m_e > 0) begin
      check("enable", 128'(ENABLE), 128'(m_en));
      check("busy", 128'(BUSY), 128'(m_busy));
      check("upper", TEXT_STRING_UPPER, m_upper);
      check("lower", TEXT_STRING_LOWER, m_lower);
      rises   <= rises + ((ENABLE && !en_prev) ? 1 : 0);
      en_prev <= ENABLE;
    end
  end

  task automatic set_hex(input bit h);
`ifdef TLCD_HEX_EN
    HEX_MODE = h;
`else
    if (h) $display("note: hex request ignored in decimal build");
`endif
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY && k < LAST + 50) begin
      @(negedge CLK);
      k++;
    end
    #1;
    check("idle_timeout", 128'(BUSY), 128'(0));
  endtask

  // One-cycle request from idle; pins ENABLE latency and width.
  task automatic req(input logic [127:0] t, input logic [15:0] v, input bit h);
    int n;
    int w;
    @(negedge CLK);
    #1;
    TITLE  = t;
    VALUE  = v;
    set_hex(h);
    UPDATE = 1'b1;
    @(negedge CLK);
    #1;
    UPDATE = 1'b0;
    n = 1;
    while (!ENABLE && n < 100) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("enable_latency", 128'(n), 128'(19));
    w = 0;
    while (ENABLE && w < 50) begin
      @(negedge CLK);
      #1;
      w++;
    end
    check("enable_width", 128'(w), 128'(EH));
  endtask

  task automatic rand_cycle();
    logic [15:0] bnd [9];
    bnd = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd10000, 16'd65535};
    @(negedge CLK);
    #1;
    UPDATE = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: VALUE = 16'($urandom_range(0, 65535));
        1: VALUE = 16'($urandom_range(0, 9));
        2: VALUE = 16'($urandom_range(0, 999));
        default: VALUE = bnd[$urandom_range(0, 8)];
      endcase
    end
    if ($urandom_range(0, 7) == 0) begin
      for (int j = 0; j < 16; j++) TITLE[127-8*j -: 8] = 8'($urandom_range(32, 126));
    end
    if ($urandom_range(0, 3) == 0) set_hex(bit'($urandom_range(0, 1)));
  endtask

  initial begin : stim
    int r0;
    RESETN = 1'b0;
    UPDATE = 1'b0;
    TITLE  = BL;
    VALUE  = '0;
    set_hex(1'b0);
    repeat (3) @(negedge CLK);
    #1 RESETN = 1'b1;
    repeat (30) @(negedge CLK);
    #1;
    check("idle_upper", TEXT_STRING_UPPER, BL);
    check("idle_lower", TEXT_STRING_LOWER, BL);
    check("idle_busy", 128'(BUSY), 128'(0));
    check("idle_rises", 128'(rises), 128'(0));

    req(s2b("SCORE"), 16'd12345, 1'b0);
    check("score_upper", TEXT_STRING_UPPER, s2b("SCORE           "));
    check("score_lower", TEXT_STRING_LOWER, s2b("VALUE = 12345   "));
    check("model_pin", m_lower, s2b("VALUE = 12345   "));
    wait_idle();

    req(s2b("ZERO"), 16'd0, 1'b0);
    check("zero_lower", TEXT_STRING_LOWER, s2b("VALUE =     0   "));
    wait_idle();
    req(s2b("MAX"), 16'd65535, 1'b0);
    check("max_lower", TEXT_STRING_LOWER, s2b("VALUE = 65535   "));
    wait_idle();
    req(s2b("HUNDRED"), 16'd100, 1'b0);
    check("hundred_lower", TEXT_STRING_LOWER, s2b("VALUE =   100   "));
    check("model_pin2", m_lower, s2b("VALUE =   100   "));
    wait_idle();

    // Three requests during HOLD coalesce into one refresh with the value current at acceptance.
    req(s2b("SCORE"), 16'd12345, 1'b0);
    r0 = rises;
    repeat (3) @(negedge CLK);
    #1 VALUE = 16'd7;
    for (int p = 0; p < 3; p++) begin
      @(negedge CLK);
      #1 UPDATE = 1'b1;
      @(negedge CLK);
      #1 UPDATE = 1'b0;
    end
    repeat (2 * LAST + 20) @(negedge CLK);
    #1;
    check("coalesce_rises", 128'(rises - r0), 128'(1));
    check("coalesce_lower", TEXT_STRING_LOWER, s2b("VALUE =     7   "));

    // Reset in the middle of conversion, with a pending request queued.
    @(negedge CLK);
    #1;
    VALUE  = 16'd54321;
    UPDATE = 1'b1;
    @(negedge CLK);
    #1 UPDATE = 1'b0;
    repeat (2) @(negedge CLK);
    #1 UPDATE = 1'b1;
    @(negedge CLK);
    #1 UPDATE = 1'b0;
    repeat (4) @(negedge CLK);
    #1 RESETN = 1'b0;
    #1;
    check("rst_upper", TEXT_STRING_UPPER, BL);
    check("rst_lower", TEXT_STRING_LOWER, BL);
    check("rst_busy", 128'(BUSY), 128'(0));
    check("rst_enable", 128'(ENABLE), 128'(0));
    r0 = rises;
    repeat (2) @(negedge CLK);
    #1 RESETN = 1'b1;
    repeat (100) @(negedge CLK);
    #1;
    check("rst_no_enable", 128'(rises - r0), 128'(0));

`ifdef TLCD_HEX_EN
    req(s2b("HEX"), 16'h00AF, 1'b1);
    check("hex_lower", TEXT_STRING_LOWER, s2b("VALUE = 0x00AF  "));
    wait_idle();
    set_hex(1'b0);
`endif

    for (int i = 0; i < 3000; i++) rand_cycle();
    @(negedge CLK);
    #1 UPDATE = 1'b0;
    repeat (2 * LAST + 10) @(negedge CLK);
    #1;
    check("final_idle", 128'(BUSY), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlcd_text_formatter.md
# tlcd_text_formatter

- Upstream stage of the text-LCD controller.
- Accepts a 16-character title and a 16-bit binary value, converts the value to right-aligned decimal ASCII with a sequential double-dabble, and builds the two 16-byte line strings.
- Issues a rising edge on ENABLE to start a display refresh, then holds the strings stable and suppresses further ENABLE edges until the downstream refresh has completed.

## Interface

Parameters:
- ENABLE_HIGH, 2: cycles ENABLE stays high per refresh request (≥1).
- REFRESH_HOLD, 65000: cycles after ENABLE falls during which strings are frozen and no new request is issued. Must exceed the downstream worst-case refresh duration; 17-bit counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- UPDATE  input  1  refresh request, level-sampled each cycle.
- TITLE  input  128  upper-line ASCII; character 0 (leftmost) in [127:120].
- VALUE  input  16  unsigned binary value for the lower line.
- HEX_MODE  input  1  present only with TLCD_HEX_EN; 1 = hex rendering.
- TEXT_STRING_UPPER  output  128  registered upper line; character 0 in [127:120].
- TEXT_STRING_LOWER  output  128  registered lower line; same byte order.
- ENABLE  output  1  registered refresh strobe to the LCD controller.
- BUSY  output  1  high whenever state ≠ IDLE.

## Operation

- States: IDLE → CONV → FMT → PULSE → HOLD → IDLE.
- **IDLE**
  - UPDATE=1 or pending=1 → latch TITLE, VALUE (and HEX_MODE), clear pending, clear the 20-bit BCD shift register, iteration count=0, go to CONV.
- **CONV**
  - One double-dabble iteration per cycle: each BCD nibble ≥5 gets +3, then shift left 1, taking the next VALUE bit MSB first.
  - Exactly 16 iterations, then go to FMT.
  - Hex mode also spends 16 cycles here, so latency is mode-independent.
- **FMT**
  - Write TEXT_STRING_UPPER = latched TITLE.
  - Write TEXT_STRING_LOWER = "VALUE = " (8 chars), then 5 digits, then 3 spaces (0x20).
  - Digits are ASCII 0x30+BCD, ten-thousands first.
  - Leading zeros are blanked to 0x20; the units digit is never blanked.
  - Go to PULSE.
- **PULSE**
  - ENABLE=1 for ENABLE_HIGH cycles, then ENABLE=0 and go to HOLD.
- **HOLD**
  - Count REFRESH_HOLD cycles, then go to IDLE.
- **Pending**
  - UPDATE=1 in any state other than IDLE sets a single pending flag; multiple requests coalesce into one.
  - Data is captured at acceptance in IDLE, i.e. the latest TITLE/VALUE, not the values present when the request was made.
- **Strings** change only in FMT, so they are frozen from FMT through the end of HOLD.
- **Arithmetic**
  - VALUE is 0..65535.
  - BCD register is 20 bits, 5 nibbles; no overflow is possible.
- **Reset** (asynchronous, any state)
  - State=IDLE, pending=0, ENABLE=0, BUSY=0.
  - TEXT_STRING_UPPER and TEXT_STRING_LOWER = all 0x20.
  - Latched data and counters cleared.
  - A conversion in progress is discarded and no ENABLE is emitted.

## Timing

- Edge E0 samples UPDATE=1 in IDLE; BUSY=1 after E0.
- Edges E1..E16 perform the conversion; E16 moves to FMT.
- E17 updates the strings.
- E18 sets ENABLE=1; ENABLE falls at edge E18+ENABLE_HIGH.
- BUSY falls at edge E18+ENABLE_HIGH+REFRESH_HOLD; a pending request is then accepted on the next edge.
- Strings are stable at least one cycle before the ENABLE rising edge.
- Minimum spacing between ENABLE rising edges: 18 + ENABLE_HIGH + REFRESH_HOLD + 1 cycles.
- UPDATE asserted on the same edge that returns the block to IDLE sets pending and is served on the next cycle (no loss).

## Configuration

- Macro: TLCD_HEX_EN.
- **Defined**
  - HEX_MODE port exists.
  - A latched HEX_MODE=1 renders the lower line as "VALUE = 0x" + 4 uppercase hex digits (0-9 → 0x30-0x39, A-F → 0x41-0x46) + 2 spaces.
  - Hex digits are never blanked.
  - HEX_MODE=0 gives the decimal rendering.
- **Undefined**
  - No HEX_MODE port and no hex logic; decimal rendering only.

## Test plan

- Reset release with UPDATE=0 → both strings all 0x20, ENABLE=0, BUSY=0 indefinitely.
- TITLE="SCORE", space-padded to 16; VALUE=12345; one-cycle UPDATE → lower line "VALUE = 12345   ", upper = TITLE at E17; ENABLE high exactly cycles E18..E18+1 (ENABLE_HIGH=2).
- Blanking boundaries:
  - VALUE=0 → "VALUE =     0   ".
  - VALUE=65535 → "VALUE = 65535   ".
  - VALUE=100 → "VALUE =   100   ".
- Change VALUE to 7 and pulse UPDATE three times during HOLD → exactly one further ENABLE pulse, with "VALUE =     7   ", starting at the first cycle after BUSY falls plus 18.
- Assert RESETN=0 at CONV iteration 8 → ENABLE never rises, strings return to all 0x20 immediately, pending cleared.
- With TLCD_HEX_EN defined: HEX_MODE=1, VALUE=0x00AF → "VALUE = 0x00AF  " with identical E17/E18 timing.
